fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, legal 2..4, meaning the fetch credit limit (in-flight requests + buffered instructions).
REQ-003 The block SHALL have port clock  input  1  rising-edge clock.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 The block SHALL have port imem_req_addr  output  32  fetch byte address, bits [1:0] always 0.
REQ-007 The block SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 The block SHALL have port imem_rsp_valid  input  1  in-order response valid, at least 1 cycle after acceptance.
REQ-009 The block SHALL have port imem_rsp_data  input  32  instruction word.
REQ-010 The block SHALL have port redirect_valid  input  1  branch/jump redirect, single-cycle pulse.
REQ-011 The block SHALL have port redirect_pc  input  32  redirect target.
REQ-012 The block SHALL have port if_valid  output  1  instruction available to decode.
REQ-013 The block SHALL have port if_pc  output  32  address of presented instruction.
REQ-014 The block SHALL have port if_instr  output  32  presented instruction.
REQ-015 The block SHALL have port if_ready  input  1  decode accepts; low = stall.

Function
REQ-016 The block SHALL hold a fetch PC register; a request handshake (imem_req_valid & imem_req_ready) SHALL advance it by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 imem_req_addr SHALL equal the fetch PC.
REQ-018 imem_req_valid SHALL be 1 only when registered (outstanding + buffered) < DEPTH, reset is low and redirect_valid is low.
REQ-019 While imem_req_valid is high without ready, imem_req_addr SHALL stay stable; only redirect may withdraw the request.
REQ-020 Each accepted request SHALL push its address into an in-flight address FIFO (DEPTH entries); each response SHALL pop it and pair the popped address with imem_rsp_data.
REQ-021 Non-discarded responses SHALL be written into a DEPTH-entry instruction FIFO {pc, instr}; if_valid/if_pc/if_instr SHALL present the FIFO head, registered, no combinational path from imem_rsp_* to if_*.
REQ-022 Latency: request accepted in cycle N, response in cycle N+k, k>=1; if_valid SHALL rise in cycle N+k+1 when the FIFO was empty.
REQ-023 An entry SHALL pop on if_valid & if_ready; simultaneous push and pop SHALL keep occupancy unchanged with order preserved.
REQ-024 On redirect_valid: fetch PC SHALL load {redirect_pc[31:2],2'b00}; the instruction FIFO SHALL be cleared; if_valid SHALL be 0 the following cycle; no request SHALL be issued that cycle.
REQ-025 On redirect, the discard counter SHALL load the outstanding count remaining after any response in that same cycle; a response in the redirect cycle SHALL be dropped.
REQ-026 While the discard counter is nonzero, each response SHALL decrement it, pop the address FIFO, and not be written to the instruction FIFO.
REQ-027 Discarded in-flight requests SHALL still count toward credits (REQ-018) until their response returns.
REQ-028 A redirect arriving while discards are pending SHALL reload the discard counter per REQ-025 (all older requests discarded).
REQ-029 A response with outstanding == 0 is a protocol error; the block SHALL ignore it and change no state.

Reset
REQ-030 While reset is high: fetch PC = RESET_PC, all counters/FIFOs empty, imem_req_valid = 0, if_valid = 0, if_pc = 0, if_instr = 0.
REQ-031 Reset SHALL override redirect and any handshake in the same cycle; mid-operation reset SHALL drop all in-flight tracking (responses after reset are protocol errors per REQ-029).
REQ-032 The first request (addr = RESET_PC) SHALL be asserted in the first cycle after reset deasserts.

Verification
REQ-033 Reset, ready=1, 1-cycle memory, if_ready=1 -> addresses 0x0,0x4,0x8 issued; if_pc 0x0 presented two cycles after first acceptance, order preserved.
REQ-034 if_ready=0 held, DEPTH=2 -> exactly 2 requests accepted, imem_req_valid then 0; release if_ready -> fetch resumes at 0x8.
REQ-035 Two requests (0x10,0x14) in flight, redirect_pc=0x203 -> next request addr 0x200; both old responses dropped; first if_pc = 0x200.
REQ-036 Redirect in the same cycle as a response and a pending request -> response dropped, no request that cycle, discard counter = remaining outstanding.
REQ-037 RESET_PC=32'hFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-038 Reset asserted with 2 in flight and full FIFO -> all outputs reset values next cycle; first request RESET_PC after deassert.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited fetch requests, in-order response pairing,
// redirect with discard of stale responses, and a registered instruction buffer to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] buffered;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] outstanding_after_rsp;

    logic [31:0]   addr_mem  [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] addr_wr, addr_rd;
    logic [PW-1:0] buf_wr, buf_rd;

    logic req_fire;
    logic rsp_fire;
    logic rsp_keep;
    logic if_fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Discarded requests keep their credit until their response comes back.
    assign imem_req_valid = !reset && !redirect_valid && ((outstanding + buffered) < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire = !reset && imem_rsp_valid && (outstanding != '0);
    assign rsp_keep = rsp_fire && !redirect_valid && (discard_cnt == '0);
    assign outstanding_after_rsp = outstanding - CW'(rsp_fire);

    assign if_valid = !reset && (buffered != '0);
    assign if_pc    = if_valid ? pc_mem[buf_rd]    : '0;
    assign if_instr = if_valid ? instr_mem[buf_rd] : '0;
    assign if_fire  = if_valid && if_ready && !redirect_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            addr_wr     <= '0;
            addr_rd     <= '0;
            buffered    <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
        end else begin
            if (redirect_valid)
                fetch_pc <= redirect_pc & ~32'h3;
            else if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;

            outstanding <= outstanding_after_rsp + CW'(req_fire);
            if (req_fire) addr_wr <= ptr_inc(addr_wr);
            if (rsp_fire) addr_rd <= ptr_inc(addr_rd);

            // Every request still in flight after this cycle's response is stale.
            if (redirect_valid)
                discard_cnt <= outstanding_after_rsp;
            else if (rsp_fire && discard_cnt != '0)
                discard_cnt <= discard_cnt - 1'b1;

            if (redirect_valid) begin
                buffered <= '0;
                buf_wr   <= '0;
                buf_rd   <= '0;
            end else begin
                if (rsp_keep) buf_wr <= ptr_inc(buf_wr);
                if (if_fire)  buf_rd <= ptr_inc(buf_rd);
                buffered <= buffered + CW'(rsp_keep) - CW'(if_fire);
            end
        end
    end

    // NOTE: storage arrays carry no reset; occupancy counters alone decide what is valid.
    always_ff @(posedge clock) begin
        if (req_fire)
            addr_mem[addr_wr] <= fetch_pc;
        if (rsp_keep) begin
            pc_mem[buf_wr]    <= addr_mem[addr_rd];
            instr_mem[buf_wr] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based memory model answers one cycle after
// acceptance; issued addresses and presented instructions are logged and checked.
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b1;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_instr;

    int n_vec = 0;
    int n_err = 0;
    bit auto_rsp = 1'b1;
    logic [31:0] mem_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] pres_pc[$];
    logic [31:0] pres_instr[$];

    fetch_unit u_dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .if_ready(if_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clock(clock), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(w_if_valid), .if_pc(w_if_pc),
        .if_instr(w_if_instr), .if_ready(if_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic arm_rsp();
        if (mem_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0]);
        end else begin
            imem_rsp_valid = 1'b0;
        end
    endtask

    // One clock: sample handshakes before the edge, update the memory model after it.
    task automatic cycle();
        logic        acc;
        logic [31:0] acc_addr;
        logic        rsp_now;
        #1;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        rsp_now  = imem_rsp_valid;
        if (if_valid && if_ready) begin
            pres_pc.push_back(if_pc);
            pres_instr.push_back(if_instr);
        end
        @(posedge clock);
        #1;
        if (rsp_now && mem_q.size() > 0) void'(mem_q.pop_front());
        if (acc) begin
            mem_q.push_back(acc_addr);
            acc_log.push_back(acc_addr);
        end
        if (auto_rsp) arm_rsp();
        else imem_rsp_valid = 1'b0;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        mem_q.delete();
        run(2);
        mem_q.delete();
        imem_rsp_valid = 1'b0;
        reset = 1'b0;
        acc_log.delete();
        pres_pc.delete();
        pres_instr.delete();
        #1;
    endtask

    task automatic check_acc(input int idx, input logic [31:0] exp);
        if (idx < acc_log.size()) check($sformatf("acc[%0d]", idx), acc_log[idx], exp);
        else check($sformatf("acc_missing[%0d]", idx), 32'(acc_log.size()), 32'(idx + 1));
    endtask

    task automatic check_pres(input int idx, input logic [31:0] exp_pc);
        if (idx < pres_pc.size()) begin
            check($sformatf("pres_pc[%0d]", idx), pres_pc[idx], exp_pc);
            check($sformatf("pres_instr[%0d]", idx), pres_instr[idx], instr_of(exp_pc));
        end else begin
            check($sformatf("pres_missing[%0d]", idx), 32'(pres_pc.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        // Reset values
        run(2);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_wrap_valid", 32'(w_req_valid), 32'd0);

        // Streaming fetch with 1-cycle memory
        reset = 1'b0;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        check("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
        cycle();
        check("wrap_second_addr", w_req_addr, 32'h0000_0000);
        check("lat_if_valid_n1", 32'(if_valid), 32'd0);
        cycle();
        check("lat_if_valid_n2", 32'(if_valid), 32'd1);
        check("lat_if_pc_n2", if_pc, 32'h0);
        run(8);
        check_acc(0, 32'h0);
        check_acc(1, 32'h4);
        check_acc(2, 32'h8);
        check_pres(0, 32'h0);
        check_pres(1, 32'h4);
        check_pres(2, 32'h8);

        // Decode stall: credits exhausted after two requests
        do_reset();
        if_ready = 1'b0;
        run(8);
        check("stall_acc_count", 32'(acc_log.size()), 32'd2);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_if_pc", if_pc, 32'h0);
        if_ready = 1'b1;
        run(6);
        check_acc(2, 32'h8);
        check_pres(0, 32'h0);
        check_pres(1, 32'h4);
        check_pres(2, 32'h8);

        // Redirect with two requests in flight
        do_reset();
        auto_rsp       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        #1;
        check("redir_no_req", 32'(imem_req_valid), 32'd0);
        cycle();
        redirect_valid = 1'b0;
        run(2);
        check_acc(0, 32'h10);
        check_acc(1, 32'h14);
        check("inflight_req_valid", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("redir_addr", imem_req_addr, 32'h200);
        check("redir_credit_held", 32'(imem_req_valid), 32'd0);
        check("redir_if_valid", 32'(if_valid), 32'd0);
        auto_rsp = 1'b1;
        arm_rsp();
        run(8);
        check_acc(2, 32'h200);
        check_pres(0, 32'h200);
        check_pres(1, 32'h204);

        // Redirect coinciding with a response and a pending request
        do_reset();
        auto_rsp = 1'b0;
        cycle();
        check("pending_req_valid", 32'(imem_req_valid), 32'd1);
        arm_rsp();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        #1;
        check("coinc_no_req", 32'(imem_req_valid), 32'd0);
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("coinc_if_valid", 32'(if_valid), 32'd0);
        check("coinc_req_addr", imem_req_addr, 32'h300);
        check("coinc_req_valid", 32'(imem_req_valid), 32'd1);
        auto_rsp = 1'b1;
        run(6);
        check_pres(0, 32'h300);

        // Reset with a full instruction buffer, then a stray response
        do_reset();
        if_ready = 1'b0;
        run(6);
        check("full_if_valid", 32'(if_valid), 32'd1);
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        reset = 1'b1;
        mem_q.delete();
        auto_rsp = 1'b0;
        imem_rsp_valid = 1'b0;
        cycle();
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("mid_rst_if_valid", 32'(if_valid), 32'd0);
        check("mid_rst_if_pc", if_pc, 32'h0);
        check("mid_rst_if_instr", if_instr, 32'h0);
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        #1;
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_rst_req_addr", imem_req_addr, 32'h0);
        cycle();
        check("stray_if_valid", 32'(if_valid), 32'd0);
        check("stray_req_addr", imem_req_addr, 32'h0);
        check("stray_req_valid", 32'(imem_req_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
